// File: rtl/memory_responder_if.sv
// Memory handshake bundle between the LC-3 control logic (master) and the
// memory responder (slave).
//   mio_en : access request, level, held until r is seen
//   r_w    : 1 = write, 0 = read
//   mar    : address
//   mdr    : write data
//   r      : ready, access completed
//   rdata  : read data, valid while r=1 for a read
interface memory_responder_if;
  logic        mio_en;
  logic        r_w;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        r;
  logic [15:0] rdata;

  modport master (
    output mio_en, r_w, mar, mdr,
    input  r, rdata
  );

  modport slave (
    input  mio_en, r_w, mar, mdr,
    output r, rdata
  );
endinterface

// File: rtl/memory_responder.sv
// Target side of the LC-3 memory handshake. Captures a request, waits a
// fixed number of wait states (RAM or device latency), performs the access
// and raises ready until the request is withdrawn. Holds the RAM array and
// the KBSR/KBDR/DSR/DDR device registers.
// Ports:
//   i_CLK, i_RST_n : clock, asynchronous active-low reset
//   bus            : memory handshake (slave side)
//   i_KB_valid/i_KB_data              : keyboard character strobe
//   o_DISP_valid/o_DISP_data/i_DISP_ready : display character handshake
module memory_responder #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned RAM_LAT  = 3,
  parameter int unsigned MMIO_LAT = 1
) (
  input  logic                i_CLK,
  input  logic                i_RST_n,
  memory_responder_if.slave   bus,
  input  logic                i_KB_valid,
  input  logic [7:0]          i_KB_data,
  output logic                o_DISP_valid,
  output logic [7:0]          o_DISP_data,
  input  logic                i_DISP_ready
);

  localparam logic [15:0] AddrKbsr = 16'hFE00;
  localparam logic [15:0] AddrKbdr = 16'hFE02;
  localparam logic [15:0] AddrDsr  = 16'hFE04;
  localparam logic [15:0] AddrDdr  = 16'hFE06;

  localparam int unsigned MaxLat = (RAM_LAT > MMIO_LAT) ? RAM_LAT : MMIO_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            r_w_q, r_w_d;
  logic [15:0]     mar_q, mar_d;
  logic [15:0]     mdr_q, mdr_d;
  logic            r_q, r_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            ram_sel_q, ram_sel_d;
  logic            kbsr_q, kbsr_d;
  logic [7:0]      kbdr_q, kbdr_d;
  logic            disp_valid_q, disp_valid_d;
  logic [7:0]      disp_data_q, disp_data_d;

  logic              access;
  logic              live_dev;
  logic              is_ram;
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       ram_rdata_q;
  logic [15:0]       mem [2**ADDR_W];

  assign live_dev = (bus.mar == AddrKbsr) || (bus.mar == AddrKbdr) ||
                    (bus.mar == AddrDsr)  || (bus.mar == AddrDdr);
  assign is_ram   = ((mar_q >> ADDR_W) == 16'd0);
  assign ram_idx  = mar_q[ADDR_W-1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    r_w_d        = r_w_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    r_d          = r_q;
    rdata_d      = rdata_q;
    ram_sel_d    = ram_sel_q;
    kbsr_d       = kbsr_q;
    kbdr_d       = kbdr_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    access       = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.mio_en) begin
          r_w_d   = bus.r_w;
          mar_d   = bus.mar;
          mdr_d   = bus.mdr;
          cnt_d   = live_dev ? CntW'(MMIO_LAT - 1) : CntW'(RAM_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        // Withdrawn request aborts with no side effects, even on the last cycle.
        if (!bus.mio_en) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          access  = 1'b1;
          r_d     = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        // Level handshake: stay ready until the master drops its request.
        if (!bus.mio_en) begin
          r_d       = 1'b0;
          rdata_d   = 16'h0000;
          ram_sel_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (access) begin
      rdata_d   = 16'h0000;
      ram_sel_d = 1'b0;
      if (mar_q == AddrKbsr) begin
        if (!r_w_q) rdata_d = {kbsr_q, 15'b0};
      end else if (mar_q == AddrKbdr) begin
        if (!r_w_q) begin
          rdata_d = {8'h00, kbdr_q};
          kbsr_d  = 1'b0;
        end
      end else if (mar_q == AddrDsr) begin
        if (!r_w_q) rdata_d = {~disp_valid_q, 15'b0};
      end else if (mar_q == AddrDdr) begin
        if (!r_w_q) begin
          rdata_d = {8'h00, disp_data_q};
        end else if (!disp_valid_q) begin
          disp_data_d  = mdr_q[7:0];
          disp_valid_d = 1'b1;
        end
      end else if (is_ram) begin
        ram_sel_d = !r_w_q;
      end
    end

    if (disp_valid_q && i_DISP_ready) disp_valid_d = 1'b0;

    // A new character wins over a same-cycle KBDR read clearing the flag.
    if (i_KB_valid) begin
      kbdr_d = i_KB_data;
      kbsr_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      r_w_q        <= 1'b0;
      mar_q        <= 16'h0000;
      mdr_q        <= 16'h0000;
      r_q          <= 1'b0;
      rdata_q      <= 16'h0000;
      ram_sel_q    <= 1'b0;
      kbsr_q       <= 1'b0;
      kbdr_q       <= 8'h00;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      r_w_q        <= r_w_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      r_q          <= r_d;
      rdata_q      <= rdata_d;
      ram_sel_q    <= ram_sel_d;
      kbsr_q       <= kbsr_d;
      kbdr_q       <= kbdr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end

  // Single-port synchronous RAM, contents survive reset.
  always_ff @(posedge i_CLK) begin
    if (access && is_ram) begin
      if (r_w_q) mem[ram_idx] <= mdr_q;
      else       ram_rdata_q  <= mem[ram_idx];
    end
  end

  assign bus.r        = r_q;
  assign bus.rdata    = ram_sel_q ? ram_rdata_q : rdata_q;
  assign o_DISP_valid = disp_valid_q;
  assign o_DISP_data  = disp_data_q;

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned RAM_LAT  = 3;
  localparam int unsigned MMIO_LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_valid = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       disp_valid;
  logic [7:0] disp_data;
  logic       disp_ready = 1'b0;

  memory_responder_if bus ();

  memory_responder #(
    .ADDR_W  (ADDR_W),
    .RAM_LAT (RAM_LAT),
    .MMIO_LAT(MMIO_LAT)
  ) dut (
    .i_CLK       (clk),
    .i_RST_n     (rst_n),
    .bus         (bus),
    .i_KB_valid  (kb_valid),
    .i_KB_data   (kb_data),
    .o_DISP_valid(disp_valid),
    .o_DISP_data (disp_data),
    .i_DISP_ready(disp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory map state kept as plain values.
  logic [15:0] m_mem [int];
  bit          m_kbsr   = 1'b0;
  logic [7:0]  m_kbdr   = 8'h00;
  bit          m_dvalid = 1'b0;
  logic [7:0]  m_ddata  = 8'h00;
  logic [15:0] ram_pool [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_dev(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
  endfunction

  task automatic model_kb(input logic [7:0] c);
    m_kbsr = 1'b1;
    m_kbdr = c;
  endtask

  task automatic model_access(input bit rw, input logic [15:0] a, input logic [15:0] d,
                              output logic [15:0] res);
    res = 16'h0000;
    if (a == 16'hFE00) begin
      if (!rw) res = m_kbsr ? 16'h8000 : 16'h0000;
    end else if (a == 16'hFE02) begin
      if (!rw) begin
        res    = {8'h00, m_kbdr};
        m_kbsr = 1'b0;
      end
    end else if (a == 16'hFE04) begin
      if (!rw) res = m_dvalid ? 16'h0000 : 16'h8000;
    end else if (a == 16'hFE06) begin
      if (!rw) res = {8'h00, m_ddata};
      else if (!m_dvalid) begin
        m_ddata  = d[7:0];
        m_dvalid = 1'b1;
      end
    end else if (int'(a) < (1 << ADDR_W)) begin
      if (rw) m_mem[int'(a)] = d;
      else if (m_mem.exists(int'(a))) res = m_mem[int'(a)];
    end
  endtask

  // One full handshake. kb_at = edge index (0 = capture edge) carrying a
  // keyboard strobe, -1 for none. hold = cycles request stays up after ready.
  task automatic do_access(input bit rw, input logic [15:0] a, input logic [15:0] d,
                           input int hold, input int kb_at, input logic [7:0] kb_char,
                           input string tag);
    int          lat_exp;
    int          edges;
    bit          done;
    logic [15:0] exp_rd;
    lat_exp = is_dev(a) ? int'(MMIO_LAT) : int'(RAM_LAT);
    if (kb_at >= 0 && kb_at < lat_exp) model_kb(kb_char);
    model_access(rw, a, d, exp_rd);
    if (kb_at == lat_exp) model_kb(kb_char);

    bus.mio_en = 1'b1;
    bus.r_w    = rw;
    bus.mar    = a;
    bus.mdr    = d;
    edges = 0;
    done  = 1'b0;
    while (!done && edges <= lat_exp + 10) begin
      kb_valid = (edges == kb_at);
      kb_data  = kb_char;
      tick();
      if (bus.r === 1'b1) done = 1'b1;
      else edges++;
    end
    kb_valid = 1'b0;
    check({tag, " ready"}, 32'(done), 32'd1);
    check({tag, " latency"}, edges, lat_exp);
    check({tag, " rdata"}, bus.rdata, exp_rd);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold ready"}, 32'(bus.r), 32'd1);
      check({tag, " hold rdata"}, bus.rdata, exp_rd);
    end
    bus.mio_en = 1'b0;
    tick();
    check({tag, " release"}, 32'(bus.r), 32'd0);
    check({tag, " disp_valid"}, 32'(disp_valid), 32'(m_dvalid));
    check({tag, " disp_data"}, disp_data, m_ddata);
  endtask

  task automatic kb_strobe(input logic [7:0] c);
    kb_valid = 1'b1;
    kb_data  = c;
    tick();
    kb_valid = 1'b0;
    model_kb(c);
  endtask

  task automatic ready_pulse();
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    m_dvalid   = 1'b0;
    check("ready pulse disp_valid", 32'(disp_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    int          op;
    bus.mio_en = 1'b0;
    bus.r_w    = 1'b0;
    bus.mar    = 16'h0000;
    bus.mdr    = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset r", 32'(bus.r), 32'd0);
    check("reset rdata", bus.rdata, 16'h0000);
    check("reset disp_valid", 32'(disp_valid), 32'd0);
    check("reset disp_data", disp_data, 8'h00);
    rst_n = 1'b1;
    tick();
    do_access(1'b0, 16'hFE00, 16'h0, 0, -1, 8'h0, "reset kbsr");
    do_access(1'b0, 16'hFE02, 16'h0, 0, -1, 8'h0, "reset kbdr");

    // RAM write then read back
    do_access(1'b1, 16'h0010, 16'h1234, 0, -1, 8'h0, "t1 write");
    do_access(1'b0, 16'h0010, 16'h0000, 0, -1, 8'h0, "t1 read");

    // Request held past ready, then a fresh capture
    do_access(1'b0, 16'h0010, 16'h0000, 2, -1, 8'h0, "t2 hold");
    do_access(1'b1, 16'h0011, 16'h5A5A, 2, -1, 8'h0, "t2 hold write");
    do_access(1'b0, 16'h0011, 16'h0000, 0, -1, 8'h0, "t2 recapture");

    // Keyboard
    kb_strobe(8'h41);
    do_access(1'b0, 16'hFE00, 16'h0, 0, -1, 8'h0, "t3 kbsr set");
    do_access(1'b0, 16'hFE02, 16'h0, 0, -1, 8'h0, "t3 kbdr");
    do_access(1'b0, 16'hFE00, 16'h0, 0, -1, 8'h0, "t3 kbsr clear");
    do_access(1'b0, 16'hFE02, 16'h0, 0, int'(MMIO_LAT), 8'h42, "t3 kb race");
    do_access(1'b0, 16'hFE00, 16'h0, 0, -1, 8'h0, "t3 kbsr after race");
    do_access(1'b1, 16'hFE02, 16'h00FF, 0, -1, 8'h0, "t3 kbdr write ignored");
    do_access(1'b0, 16'hFE02, 16'h0, 0, -1, 8'h0, "t3 kbdr new");

    // Display
    do_access(1'b1, 16'hFE06, 16'h0058, 0, -1, 8'h0, "t4 ddr write");
    do_access(1'b0, 16'hFE04, 16'h0, 0, -1, 8'h0, "t4 dsr busy");
    do_access(1'b1, 16'hFE06, 16'h0059, 0, -1, 8'h0, "t4 ddr drop");
    do_access(1'b0, 16'hFE06, 16'h0, 0, -1, 8'h0, "t4 ddr read");
    ready_pulse();
    do_access(1'b0, 16'hFE04, 16'h0, 0, -1, 8'h0, "t4 dsr idle");

    // Abort in wait, then reset in wait
    do_access(1'b1, 16'h0020, 16'h1111, 0, -1, 8'h0, "t5 prior");
    bus.mio_en = 1'b1;
    bus.r_w    = 1'b1;
    bus.mar    = 16'h0020;
    bus.mdr    = 16'hBEEF;
    tick();
    tick();
    bus.mio_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5 abort r", 32'(bus.r), 32'd0);
    end
    do_access(1'b0, 16'h0020, 16'h0, 0, -1, 8'h0, "t5 after abort");
    bus.mio_en = 1'b1;
    bus.r_w    = 1'b1;
    bus.mar    = 16'h0020;
    bus.mdr    = 16'hCAFE;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5 reset r", 32'(bus.r), 32'd0);
    bus.mio_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5 post reset r", 32'(bus.r), 32'd0);
    // Device registers reset with the block; the model follows.
    m_kbsr   = 1'b0;
    m_kbdr   = 8'h00;
    m_dvalid = 1'b0;
    m_ddata  = 8'h00;
    do_access(1'b0, 16'h0020, 16'h0, 0, -1, 8'h0, "t5 after reset");

    // Out-of-range accesses
    do_access(1'b0, 16'hF000, 16'h0, 0, -1, 8'h0, "t6 oor read");
    do_access(1'b1, 16'hF000, 16'h7777, 0, -1, 8'h0, "t6 oor write");
    do_access(1'b0, 16'hF000, 16'h0, 0, -1, 8'h0, "t6 oor reread");
    do_access(1'b0, 16'h0000, 16'h0, 0, -1, 8'h0, "t6 alias check");

    // Randomized traffic against the model
    for (int i = 0; i < 8; i++) begin
      ram_pool[i] = 16'($urandom_range(0, (1 << ADDR_W) - 1));
      do_access(1'b1, ram_pool[i], 16'($urandom), 0, -1, 8'h0, "rnd init");
    end
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 7));
      d  = 16'($urandom);
      case (op)
        0: do_access(1'b1, ram_pool[$urandom_range(0, 7)], d,
                     int'($urandom_range(0, 2)), -1, 8'h0, "rnd ram write");
        1: do_access(1'b0, ram_pool[$urandom_range(0, 7)], d,
                     int'($urandom_range(0, 2)), -1, 8'h0, "rnd ram read");
        2: kb_strobe(d[7:0]);
        3: begin
          a = ($urandom_range(0, 1) == 0) ? 16'hFE00 : 16'hFE02;
          do_access(1'b0, a, d, 0, int'($urandom_range(0, 2)) - 1, 8'($urandom), "rnd kb read");
        end
        4: do_access(1'b1, 16'hFE06, d, 0, -1, 8'h0, "rnd ddr write");
        5: begin
          a = ($urandom_range(0, 1) == 0) ? 16'hFE04 : 16'hFE06;
          do_access(1'b0, a, d, 1, -1, 8'h0, "rnd disp read");
        end
        6: ready_pulse();
        default: begin
          a = 16'($urandom_range(1 << ADDR_W, 16'hFFFF));
          if (is_dev(a)) a = a ^ 16'h0001;
          do_access(bit'($urandom_range(0, 1)), a, d, 0, -1, 8'h0, "rnd oor");
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
